// File: rtl/serial_add_if.sv
// serial_add_if: start handshake, operand and result bundle for serial_add_ctrl.
//   master (requester)  drives start_valid, a, b, cin (and sub with ADD_SUB_EN),
//                       and receives start_ready, sum, cout, done, busy.
//   slave  (controller) is the mirror image.
// Optional feature macro: ADD_SUB_EN adds the sub (subtract select) signal.
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADD_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             done;
    logic             busy;

    modport master (
        output start_valid, a, b, cin,
`ifdef ADD_SUB_EN
        output sub,
`endif
        input  start_ready, sum, cout, done, busy
    );

    modport slave (
        input  start_valid, a, b, cin,
`ifdef ADD_SUB_EN
        input  sub,
`endif
        output start_ready, sum, cout, done, busy
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. One full-adder cell is stepped
// LSB-first over WIDTH clocks, with the carry held in a flop between steps.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_add_if.slave: start_valid/start_ready accept handshake,
//          a/b/cin operands (sampled on accept), sum/cout registered result,
//          done one-cycle completion pulse, busy high in RUN and DONE.
// Optional feature macro: ADD_SUB_EN (sub=1 computes a-b; cout=1 means no borrow).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_add_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Majority of three: the carry output of a full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        maj3 = (x & y) | (x & z) | (y & z);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             start_ready_q, start_ready_d;

    logic [WIDTH-1:0] b_load_s;
    logic             c_load_s;
    logic             fa_s_s;
    logic             fa_c_s;

    // Operand conditioning at accept: subtraction is a + ~b + 1.
    always_comb begin
`ifdef ADD_SUB_EN
        if (bus.sub) begin
            b_load_s = ~bus.b;
            c_load_s = 1'b1;
        end else begin
            b_load_s = bus.b;
            c_load_s = bus.cin;
        end
`else
        b_load_s = bus.b;
        c_load_s = bus.cin;
`endif
    end

    // The single shared full-adder cell.
    always_comb begin
        fa_s_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_c_s = maj3(a_sh_q[0], b_sh_q[0], carry_q);
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d       = state_q;
        a_sh_d        = a_sh_q;
        b_sh_d        = b_sh_q;
        sum_sh_d      = sum_sh_q;
        carry_d       = carry_q;
        cnt_d         = cnt_q;
        sum_d         = sum_q;
        cout_d        = cout_q;
        done_d        = 1'b0;
        busy_d        = busy_q;
        start_ready_d = start_ready_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_sh_d        = bus.a;
                    b_sh_d        = b_load_s;
                    carry_d       = c_load_s;
                    cnt_d         = {CW{1'b0}};
                    state_d       = RUN;
                    busy_d        = 1'b1;
                    start_ready_d = 1'b0;
                end else begin
                    busy_d        = 1'b0;
                    start_ready_d = 1'b1;
                end
            end
            RUN: begin
                carry_d  = fa_c_s;
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH steps.
                sum_sh_d = {fa_s_s, sum_sh_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = {fa_s_s, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_c_s;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d       = IDLE;
                busy_d        = 1'b0;
                start_ready_d = 1'b1;
            end
            default: begin
                state_d       = IDLE;
                busy_d        = 1'b0;
                start_ready_d = 1'b1;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_sh_q        <= {WIDTH{1'b0}};
            b_sh_q        <= {WIDTH{1'b0}};
            sum_sh_q      <= {WIDTH{1'b0}};
            carry_q       <= 1'b0;
            cnt_q         <= {CW{1'b0}};
            sum_q         <= {WIDTH{1'b0}};
            cout_q        <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            a_sh_q        <= a_sh_d;
            b_sh_q        <= b_sh_d;
            sum_sh_q      <= sum_sh_d;
            carry_q       <= carry_d;
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            cout_q        <= cout_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            start_ready_q <= start_ready_d;
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.sum         = sum_q;
    assign bus.cout        = cout_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
endmodule
